// File: rtl/gen_clk_div.sv
// rtl/gen_clk_div.sv - power-of-two clock divider with per-channel glitch-free select commit
//
// Optional feature macro: GEN_CLK_STROBE_EN (adds the stb rising-edge strobe output).
//
// One shared free-running counter feeds every channel; a channel dividing by
// 2^s simply taps counter bit s-1. Selects are only committed on the counter
// wrap, where every legal tap is 0, so a ratio change can never produce a runt.
module gen_clk_div #(
   parameter int                        CNT_W   = 3,
   parameter int                        NUM_CH  = 2,
   parameter int                        SEL_W   = 3,
   parameter logic [NUM_CH*SEL_W-1:0]   DEF_SEL = {3'd3, 3'd2}
) (
   input  logic                         clk_8f,
   input  logic                         rst,
   input  logic                         enb,
   input  logic [NUM_CH*SEL_W-1:0]      div_sel,
   output logic [NUM_CH-1:0]            clk_out,
   output logic                         locked,
   output logic                         sel_err
`ifdef GEN_CLK_STROBE_EN
   ,
   output logic [NUM_CH-1:0]            stb
`endif
);

   logic [CNT_W-1:0]          cnt;
   logic [CNT_W-1:0]          cnt_nxt;
   logic [NUM_CH*SEL_W-1:0]   act_sel;
   logic [NUM_CH*SEL_W-1:0]   act_sel_nxt;
   logic                      wrap;
   logic [NUM_CH-1:0]         clk_nxt;
   logic                      err_nxt;

   // A select is usable only if it names an existing counter bit (1..CNT_W).
   function automatic logic sel_legal(input logic [SEL_W-1:0] s);
      return (s != '0) && (int'(s) <= CNT_W);
   endfunction

   // Counter bit s-1 for a legal select, 0 otherwise (illegal channels park low).
   function automatic logic sel_tap(input logic [SEL_W-1:0] s,
                                    input logic [CNT_W-1:0] c);
      logic t;
      t = 1'b0;
      for (int b = 0; b < CNT_W; b++) begin
         if (int'(s) == b + 1) begin
            t = c[b];
         end
      end
      return t;
   endfunction

   // True when any channel field of a packed select vector is illegal.
   function automatic logic any_illegal(input logic [NUM_CH*SEL_W-1:0] v);
      logic e;
      e = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (!sel_legal(v[ch*SEL_W +: SEL_W])) begin
            e = 1'b1;
         end
      end
      return e;
   endfunction

   // Next counter / committed select / output values as seen after an enabled edge.
   always_comb begin
      wrap        = enb && (cnt == '1);
      cnt_nxt     = cnt + CNT_W'(1);
      act_sel_nxt = wrap ? div_sel : act_sel;
      clk_nxt     = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         clk_nxt[ch] = sel_tap(act_sel_nxt[ch*SEL_W +: SEL_W], cnt_nxt);
      end
      err_nxt     = any_illegal(act_sel_nxt);
   end

   // Counter, committed selects and registered outputs; enb low freezes everything.
   always_ff @(posedge clk_8f) begin
      if (!rst) begin
         cnt     <= '0;
         act_sel <= DEF_SEL;
         clk_out <= '0;
         locked  <= 1'b0;
         sel_err <= any_illegal(DEF_SEL);
      end else if (enb) begin
         cnt     <= cnt_nxt;
         act_sel <= act_sel_nxt;
         clk_out <= clk_nxt;
         sel_err <= err_nxt;
         if (wrap) begin
            locked <= 1'b1;
         end
      end
   end

`ifdef GEN_CLK_STROBE_EN
   // One-cycle pulse on the edge where a channel output goes 0 to 1.
   always_ff @(posedge clk_8f) begin
      if (!rst) begin
         stb <= '0;
      end else if (enb) begin
         stb <= clk_nxt & ~clk_out;
      end else begin
         stb <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_gen_clk_div.sv
// tb/tb_gen_clk_div.sv - scoreboard bench for gen_clk_div with directed vectors
module tb_gen_clk_div;

   logic       clk_8f = 1'b0;
   logic       rst;
   logic       enb;
   logic [5:0] div_sel;
   logic [1:0] clk_out;
   logic       locked;
   logic       sel_err;
`ifdef GEN_CLK_STROBE_EN
   logic [1:0] stb;
`endif

   typedef struct {
      logic [1:0] clk;
      logic       lock;
      logic       err;
      logic [1:0] stb;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   logic [1:0] prev_clk = 2'b00;

   gen_clk_div dut (
      .clk_8f  (clk_8f),
      .rst     (rst),
      .enb     (enb),
      .div_sel (div_sel),
      .clk_out (clk_out),
      .locked  (locked),
      .sel_err (sel_err)
`ifdef GEN_CLK_STROBE_EN
      ,
      .stb     (stb)
`endif
   );

   always #5 clk_8f = ~clk_8f;

   // Drive one cycle of stimulus and queue the hand-computed post-edge outputs.
   task automatic step(input logic r, input logic e, input logic [2:0] s1,
                       input logic [2:0] s0, input logic [1:0] c,
                       input logic l, input logic er);
      exp_t x;
      @(negedge clk_8f);
      rst     = r;
      enb     = e;
      div_sel = {s1, s0};
      x.clk   = c;
      x.lock  = l;
      x.err   = er;
      x.stb   = (r && e) ? (c & ~prev_clk) : 2'b00;
      prev_clk = c;
      q.push_back(x);
   endtask

   // Monitor: outputs are valid every cycle, so pop one expectation per edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk_8f);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (clk_out !== x.clk) begin
               errors++;
               $display("FAIL clk_out got %b want %b at %0t", clk_out, x.clk, $time);
            end
            checks++;
            if (locked !== x.lock) begin
               errors++;
               $display("FAIL locked got %b want %b at %0t", locked, x.lock, $time);
            end
            checks++;
            if (sel_err !== x.err) begin
               errors++;
               $display("FAIL sel_err got %b want %b at %0t", sel_err, x.err, $time);
            end
`ifdef GEN_CLK_STROBE_EN
            checks++;
            if (stb !== x.stb) begin
               errors++;
               $display("FAIL stb got %b want %b at %0t", stb, x.stb, $time);
            end
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; enb = 1'b0; div_sel = 6'b011_010;
      // reset, 3 cycles
      repeat (3) step(0, 1, 3, 2, 2'b00, 0, 0);
      // first period: ch0 /4, ch1 /8, locked on edge 8
      step(1,1,3,2,2'b00,0,0); step(1,1,3,2,2'b01,0,0); step(1,1,3,2,2'b01,0,0);
      step(1,1,3,2,2'b10,0,0); step(1,1,3,2,2'b10,0,0); step(1,1,3,2,2'b11,0,0);
      step(1,1,3,2,2'b11,0,0); step(1,1,3,2,2'b00,1,0);
      // cnt 1..3, then request ch0 /2 at cnt=3: still /4 until wrap
      step(1,1,3,2,2'b00,1,0); step(1,1,3,2,2'b01,1,0); step(1,1,3,2,2'b01,1,0);
      step(1,1,3,1,2'b10,1,0); step(1,1,3,1,2'b10,1,0); step(1,1,3,1,2'b11,1,0);
      step(1,1,3,1,2'b11,1,0); step(1,1,3,1,2'b00,1,0);
      // ch0 now /2
      step(1,1,3,1,2'b01,1,0); step(1,1,3,1,2'b00,1,0); step(1,1,3,1,2'b01,1,0);
      step(1,1,3,1,2'b10,1,0); step(1,1,3,1,2'b11,1,0); step(1,1,3,1,2'b10,1,0);
      step(1,1,3,1,2'b11,1,0); step(1,1,3,1,2'b00,1,0);
      // run to cnt=5, freeze 5 cycles, resume at 6
      step(1,1,3,1,2'b01,1,0); step(1,1,3,1,2'b00,1,0); step(1,1,3,1,2'b01,1,0);
      step(1,1,3,1,2'b10,1,0); step(1,1,3,1,2'b11,1,0);
      repeat (5) step(1, 0, 3, 1, 2'b11, 1, 0);
      step(1,1,3,1,2'b10,1,0); step(1,1,3,1,2'b11,1,0); step(1,1,3,1,2'b00,1,0);
      // request {0,2}: committed at next wrap, ch1 illegal
      step(1,1,0,2,2'b01,1,0); step(1,1,0,2,2'b00,1,0); step(1,1,0,2,2'b01,1,0);
      step(1,1,0,2,2'b10,1,0); step(1,1,0,2,2'b11,1,0); step(1,1,0,2,2'b10,1,0);
      step(1,1,0,2,2'b11,1,0); step(1,1,0,2,2'b00,1,1);
      step(1,1,0,2,2'b00,1,1); step(1,1,0,2,2'b01,1,1); step(1,1,0,2,2'b01,1,1);
      // restore ch1 /8 at cnt=3, committed at wrap
      step(1,1,3,2,2'b00,1,1); step(1,1,3,2,2'b00,1,1); step(1,1,3,2,2'b01,1,1);
      step(1,1,3,2,2'b01,1,1); step(1,1,3,2,2'b00,1,0);
      step(1,1,3,2,2'b00,1,0); step(1,1,3,2,2'b01,1,0); step(1,1,3,2,2'b01,1,0);
      step(1,1,3,2,2'b10,1,0); step(1,1,3,2,2'b10,1,0); step(1,1,3,2,2'b11,1,0);
      // reset at cnt=6 with enb low; div_sel junk must not leak into act_sel
      step(0,0,3,2,2'b00,0,0); step(0,1,0,1,2'b00,0,0);
      step(1,1,0,1,2'b00,0,0); step(1,1,0,1,2'b01,0,0); step(1,1,0,1,2'b01,0,0);
      step(1,1,0,1,2'b10,0,0); step(1,1,0,1,2'b10,0,0);
      // drain scoreboard with a bounded wait
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_8f);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
